// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between a display
// scanout reader (fixed top priority) and a game-logic writer (req/ack).
// Ports:
//   i_clock, i_reset (async, active-high)
//   display: i_disp_req, i_disp_addr -> o_disp_data, o_disp_valid
//   writer:  i_wr_req, i_wr_addr, i_wr_data -> o_wr_ack
//   status:  i_vblank, i_starve_clr -> o_wr_starved
//   RAM:     o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata <- i_ram_rdata
// Build option: define VBLANK_ONLY_WR_EN to restrict writes to vertical
// blanking; otherwise i_vblank is ignored.
module vram_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 4,
    parameter int STARVE_LIMIT = 800
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_disp_req,
    input  logic [AW-1:0] i_disp_addr,
    output logic [DW-1:0] o_disp_data,
    output logic          o_disp_valid,
    input  logic          i_wr_req,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_wr_ack,
    input  logic          i_vblank,
    input  logic          i_starve_clr,
    output logic          o_wr_starved,
    output logic          o_ram_en,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } state_t;

    localparam logic [15:0] LIM_M1 = 16'(STARVE_LIMIT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ram_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [DW-1:0] r_ram_wdata;
    logic [DW-1:0] w_wdata_nxt;
    logic          r_ram_en;
    logic          r_ram_we;
    logic          r_wr_ack;
    logic          r_rd_pend;
    logic [DW-1:0] r_disp_hold;
    logic [15:0]   r_cnt;
    logic [15:0]   w_cnt_nxt;
    logic          w_blocked;
    logic          r_starved;
    logic          w_wr_ok;

`ifdef VBLANK_ONLY_WR_EN
    assign w_wr_ok = i_vblank;
`else
    logic w_unused_vblank;
    assign w_unused_vblank = i_vblank;
    assign w_wr_ok = 1'b1;
`endif

    // Next op; the current ack blocks a second grant for the same request.
    always_comb begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = r_ram_addr;
        w_wdata_nxt = r_ram_wdata;
        if (i_disp_req) begin
            w_state_nxt = S_RD;
            w_addr_nxt  = i_disp_addr;
        end else if (i_wr_req && !r_wr_ack && w_wr_ok) begin
            w_state_nxt = S_WR;
            w_addr_nxt  = i_wr_addr;
            w_wdata_nxt = i_wr_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_wr_ack    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ram_addr  <= w_addr_nxt;
            r_ram_wdata <= w_wdata_nxt;
            r_ram_en    <= (w_state_nxt != S_IDLE);
            r_ram_we    <= (w_state_nxt == S_WR);
            r_wr_ack    <= (w_state_nxt == S_WR);
        end
    end

    // RAM data arrives the cycle after a read op; pass it straight through
    // and keep a copy so o_disp_data holds between reads.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_pend   <= 1'b0;
            r_disp_hold <= '0;
        end else begin
            r_rd_pend <= (r_state == S_RD);
            if (r_rd_pend) begin
                r_disp_hold <= i_ram_rdata;
            end
        end
    end

    assign w_blocked = i_wr_req && !r_wr_ack;

    always_comb begin
        w_cnt_nxt = '0;
        if (w_blocked) begin
            w_cnt_nxt = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        end
    end

    // Set only on the edge the counter steps onto the limit.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_starved <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_blocked && r_cnt == LIM_M1) begin
                r_starved <= 1'b1;
            end else if (i_starve_clr) begin
                r_starved <= 1'b0;
            end
        end
    end

    assign o_ram_en     = r_ram_en;
    assign o_ram_we     = r_ram_we;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_wdata  = r_ram_wdata;
    assign o_wr_ack     = r_wr_ack;
    assign o_disp_valid = r_rd_pend;
    assign o_disp_data  = r_rd_pend ? i_ram_rdata : r_disp_hold;
    assign o_wr_starved = r_starved;

endmodule
